// File: rtl/wddl_dr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : wddl_dr_decoder                                               |
// | Description: Receive endpoint of a WDDL dual-rail datapath. Samples the    |
// |              precharge/evaluate word, detects completion and rail faults,  |
// |              and hands the decoded single-rail word out via valid/ready.   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module wddl_dr_decoder #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WIDTH-1:0]     d_p_in,
  input  logic [WIDTH-1:0]     d_n_in,
  output logic [WIDTH-1:0]     d_out,
  output logic                 d_valid_out,
  input  logic                 d_ready_in,
  output logic                 err_out,
  output logic [ERR_CNT_W-1:0] err_cnt_out,
  output logic                 busy_out
);

  localparam logic [2:0] ST_WAIT_SP = 3'd0;
  localparam logic [2:0] ST_SPACER  = 3'd1;
  localparam logic [2:0] ST_EVAL    = 3'd2;
  localparam logic [2:0] ST_OUT     = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  // Sample (r) and previous-sample (q) stages; the rails never reach logic unregistered
  logic [WIDTH-1:0] r_p_q, r_n_q, q_p_q, q_n_q;

  logic [2:0]           state_q, state_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic w_all_sp, w_complete, w_fault, w_stable, w_hs;

  // Word-level classification of the sampled dual-rail word
  assign w_all_sp   = ~|(r_p_q | r_n_q);
  assign w_complete = &(r_p_q ^ r_n_q);
  assign w_fault    = |(r_p_q & r_n_q);
  assign w_stable   = (r_p_q == q_p_q) && (r_n_q == q_n_q);
  assign w_hs       = valid_q && d_ready_in;

  // Two-deep input pipeline used for completion and stability detection
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_p_q <= '0;
      r_n_q <= '0;
      q_p_q <= '0;
      q_n_q <= '0;
    end else begin
      r_p_q <= d_p_in;
      r_n_q <= d_n_in;
      q_p_q <= r_p_q;
      q_n_q <= r_n_q;
    end
  end

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_WAIT_SP;
    else        state_q <= state_d;
  end

  // Next-state logic; only a full spacer re-arms the decoder
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_SP: if (w_all_sp) state_d = ST_SPACER;
      ST_SPACER: begin
        if (w_fault)       state_d = ST_WAIT_SP;
        else if (!w_all_sp) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (w_fault)                     state_d = ST_WAIT_SP;
        else if (w_all_sp)               state_d = ST_SPACER;
        else if (w_complete && w_stable) state_d = ST_OUT;
      end
      ST_OUT: if (w_hs) state_d = w_all_sp ? ST_SPACER : ST_DRAIN;
      ST_DRAIN: if (!w_fault && w_all_sp) state_d = ST_SPACER;
      default: state_d = ST_WAIT_SP;
    endcase
  end

  // Output/datapath next values: capture, handshake, fault pulse and counter
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    case (state_q)
      ST_SPACER: err_d = w_fault;
      ST_EVAL: begin
        if (w_fault) begin
          err_d = 1'b1;
        end else if (!w_all_sp && w_complete && w_stable) begin
          dout_d  = r_p_q;
          valid_d = 1'b1;
        end
      end
      ST_OUT: begin
        err_d = w_fault;
        if (w_hs) valid_d = 1'b0;
      end
      ST_DRAIN: err_d = w_fault;
      default: err_d = 1'b0;
    endcase
    cnt_d = (err_d && !(&cnt_q)) ? cnt_q + ERR_CNT_W'(1) : cnt_q;
  end

  // Output registers; reset drops a pending word immediately
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d_out       = dout_q;
  assign d_valid_out = valid_q;
  assign err_out     = err_q;
  assign err_cnt_out = cnt_q;
  assign busy_out    = (state_q != ST_SPACER);

endmodule
`default_nettype wire

// File: tb/tb_wddl_dr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_wddl_dr_decoder                                            |
// | Description: Directed self-checking bench for wddl_dr_decoder, with a      |
// |              second instance using a 2-bit fault counter for saturation.   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_wddl_dr_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst2 = 1'b1;
  logic [7:0] dp = 8'h00;
  logic [7:0] dn = 8'h00;
  logic       rdy = 1'b0;

  logic [7:0] dout, dout2;
  logic       vld, vld2, err, err2, busy, busy2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;
  int vcount;

  always #5 clk = ~clk;

  wddl_dr_decoder #(.WIDTH(8), .ERR_CNT_W(8)) dut (
    .clk_in(clk), .rst_in(rst), .d_p_in(dp), .d_n_in(dn),
    .d_out(dout), .d_valid_out(vld), .d_ready_in(rdy),
    .err_out(err), .err_cnt_out(cnt), .busy_out(busy)
  );

  wddl_dr_decoder #(.WIDTH(8), .ERR_CNT_W(2)) dut2 (
    .clk_in(clk), .rst_in(rst2), .d_p_in(dp), .d_n_in(dn),
    .d_out(dout2), .d_valid_out(vld2), .d_ready_in(1'b1),
    .err_out(err2), .err_cnt_out(cnt2), .busy_out(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then sit 1 time unit past the last edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    step(1);
    rst = 1'b0;

    // Spacer for 2 cycles, then 0xA5/0x5A
    step(2);
    chk("sp_busy", 32'(busy), 32'd0);
    dp = 8'hA5; dn = 8'h5A;
    step(1);
    chk("lat_e0", 32'(vld), 32'd0);
    step(1);
    chk("lat_e1", 32'(vld), 32'd0);
    step(1);
    chk("lat_e2_vld", 32'(vld), 32'd1);
    chk("lat_e2_dout", 32'(dout), 32'hA5);
    chk("lat_e2_cnt", 32'(cnt), 32'd0);

    // Hold off consumer while rails return to spacer
    dp = 8'h00; dn = 8'h00;
    step(5);
    chk("hold_vld", 32'(vld), 32'd1);
    chk("hold_dout", 32'(dout), 32'hA5);
    rdy = 1'b1;
    step(1);
    chk("hs_vld", 32'(vld), 32'd0);
    chk("hs_busy", 32'(busy), 32'd0);

    // Bits resolve one per cycle toward 0x3C/0xC3
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      dp = 8'h3C & 8'((16'd1 << (i + 1)) - 16'd1);
      dn = 8'hC3 & 8'((16'd1 << (i + 1)) - 16'd1);
      step(1);
      vcount += int'(vld);
    end
    chk("res_partial_vld", 32'(vcount), 32'd0);
    step(1);
    chk("res_unstable_vld", 32'(vld), 32'd0);
    step(1);
    chk("res_vld", 32'(vld), 32'd1);
    chk("res_dout", 32'(dout), 32'h3C);
    vcount = 1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      vcount += int'(vld);
    end
    chk("res_once", 32'(vcount), 32'd1);
    chk("drain_busy", 32'(busy), 32'd1);

    // Fault in EVAL
    dp = 8'h00; dn = 8'h00;
    step(2);
    chk("sp2_busy", 32'(busy), 32'd0);
    dp = 8'h02; dn = 8'h00;
    step(2);
    dp = 8'h01; dn = 8'h01;
    step(2);
    chk("flt_err", 32'(err), 32'd1);
    chk("flt_cnt", 32'(cnt), 32'd1);
    chk("flt_vld", 32'(vld), 32'd0);
    dp = 8'hA5; dn = 8'h5A;
    step(1);
    chk("flt_err_pulse", 32'(err), 32'd0);
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      vcount += int'(vld);
    end
    chk("no_spacer_ignored", 32'(vcount), 32'd0);
    dp = 8'h00; dn = 8'h00;
    step(2);
    dp = 8'h5A; dn = 8'hA5; rdy = 1'b0;
    step(3);
    chk("rearm_vld", 32'(vld), 32'd1);
    chk("rearm_dout", 32'(dout), 32'h5A);

    // Asynchronous reset mid-OUT
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", 32'(vld), 32'd0);
    chk("arst_dout", 32'(dout), 32'h00);
    chk("arst_cnt", 32'(cnt), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    dp = 8'h00; dn = 8'h00;
    step(1);
    rst = 1'b0;
    step(2);
    dp = 8'hA5; dn = 8'h5A; rdy = 1'b1;
    step(3);
    chk("post_rst_vld", 32'(vld), 32'd1);
    chk("post_rst_dout", 32'(dout), 32'hA5);
    step(1);
    dp = 8'h00; dn = 8'h00;
    step(2);
    chk("post_rst_sp", 32'(busy), 32'd0);

    // Saturating counter with a 2-bit instance
    rst2 = 1'b0;
    step(2);
    chk("sat_start_busy", 32'(busy2), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      dp = 8'h10; dn = 8'h10;
      step(2);
      chk($sformatf("sat_err2_%0d", k), 32'(err2), 32'd1);
      dp = 8'h00; dn = 8'h00;
      step(2);
      chk($sformatf("sat_cnt2_%0d", k), 32'(cnt2), (k < 3) ? 32'(k) : 32'd3);
      chk($sformatf("sat_cnt_%0d", k), 32'(cnt), 32'(k));
    end

    // Handshake coinciding with a fault: word delivered, err pulses, DRAIN
    dp = 8'hA5; dn = 8'h5A; rdy = 1'b0;
    step(3);
    chk("sim_vld", 32'(vld), 32'd1);
    dp = 8'hFF; dn = 8'hFF;
    step(1);
    rdy = 1'b1;
    step(1);
    chk("sim_hs_vld", 32'(vld), 32'd0);
    chk("sim_err", 32'(err), 32'd1);
    chk("sim_cnt", 32'(cnt), 32'd6);
    chk("sim_drain", 32'(busy), 32'd1);
    dp = 8'h00; dn = 8'h00;
    step(1);
    chk("sim_drain2", 32'(busy), 32'd1);
    step(1);
    chk("sim_spacer", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
